// File: rtl/snake_pkg.sv
// Shared SnakeWars types and constants: screen selection, screen controller
// states and the menu/end-screen button geometry.
package snake_pkg;

   localparam int BUTTONS_X        = 270;
   localparam int BUTTONS_Y        = 200;
   localparam int BUTTONE_Y        = 300;
   localparam int BUTTONS_W        = 100;
   localparam int BUTTONS_H        = 40;
   localparam int END_DELAY_FRAMES = 60;

   typedef enum logic [1:0] {
      SCR_MENU = 2'd0,
      SCR_GAME = 2'd1,
      SCR_WIN  = 2'd2,
      SCR_LOSE = 2'd3
   } screen_t;

   typedef enum logic [2:0] {
      S_MENU     = 3'd0,
      S_GAME     = 3'd1,
      S_END_WAIT = 3'd2,
      S_WIN      = 3'd3,
      S_LOSE     = 3'd4
   } ctl_state_t;

   // The end-delay state keeps showing the game so the final frame stays visible.
   function automatic screen_t screen_of(input ctl_state_t s);
      case (s)
         S_GAME, S_END_WAIT: screen_of = SCR_GAME;
         S_WIN:              screen_of = SCR_WIN;
         S_LOSE:             screen_of = SCR_LOSE;
         default:            screen_of = SCR_MENU;
      endcase
   endfunction

endpackage

// File: rtl/rect_hit.sv
// Registered point-in-rectangle test on a half-open box [X, X+W) x [Y, Y+H),
// evaluated at 12 bits so the far edge cannot overflow.
module rect_hit
   import snake_pkg::*;
#(
   parameter int X = BUTTONS_X,
   parameter int Y = BUTTONS_Y,
   parameter int W = BUTTONS_W,
   parameter int H = BUTTONS_H
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] x,
   input  logic [10:0] y,
   output logic        hit
);

   localparam logic [11:0] X0 = 12'(X);
   localparam logic [11:0] X1 = 12'(X + W);
   localparam logic [11:0] Y0 = 12'(Y);
   localparam logic [11:0] Y1 = 12'(Y + H);

   logic [11:0] xe;
   logic [11:0] ye;

   assign xe = {1'b0, x};
   assign ye = {1'b0, y};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) hit <= 1'b0;
      else      hit <= (xe >= X0) && (xe < X1) && (ye >= Y0) && (ye < Y1);
   end

endmodule

// File: rtl/screen_ctl.sv
// Frame-synchronous screen sequencer: menu -> game -> end delay -> win/lose -> menu.
// Screen changes are queued as a request and applied only on frame_tick.
module screen_ctl
   import snake_pkg::*;
#(
   parameter int END_DELAY = END_DELAY_FRAMES,
   parameter int CNT_B     = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic [10:0] mouse_x,
   input  logic [10:0] mouse_y,
   input  logic        mouse_left,
   input  logic        game_over,
   input  logic        game_won,
   output screen_t     screen,
   output logic        start_game,
   output logic        busy,
   output ctl_state_t  dbg_state
);

   localparam logic [CNT_B-1:0] CNT_LAST = CNT_B'(END_DELAY - 1);

   ctl_state_t       state, state_n;
   ctl_state_t       req_state, req_state_n;
   ctl_state_t       result, result_n;
   logic             req_valid, req_valid_n;
   logic [CNT_B-1:0] cnt, cnt_n;
   logic             armed, armed_n;
   logic             mouse_left_q;
   logic             click_d, click_n;
   logic             state_chg;
   logic             start_hit, back_hit;

   rect_hit #(.X(BUTTONS_X), .Y(BUTTONS_Y), .W(BUTTONS_W), .H(BUTTONS_H)) u_start_hit (
      .clk(clk), .rst(rst), .x(mouse_x), .y(mouse_y), .hit(start_hit)
   );

   rect_hit #(.X(BUTTONS_X), .Y(BUTTONE_Y), .W(BUTTONS_W), .H(BUTTONS_H)) u_back_hit (
      .clk(clk), .rst(rst), .x(mouse_x), .y(mouse_y), .hit(back_hit)
   );

   always_comb begin
      state_n     = state;
      req_valid_n = req_valid;
      req_state_n = req_state;
      cnt_n       = cnt;
      result_n    = result;
      if (req_valid) begin
         if (frame_tick) begin
            state_n     = req_state;
            req_valid_n = 1'b0;
         end
      end else begin
         case (state)
            S_MENU: if (click_d && start_hit) begin
               req_valid_n = 1'b1;
               req_state_n = S_GAME;
            end
            S_GAME: if (game_over || game_won) begin
               state_n  = S_END_WAIT;
               cnt_n    = '0;
               result_n = game_over ? S_LOSE : S_WIN;
            end
            S_END_WAIT: if (frame_tick) begin
               if (cnt == CNT_LAST) begin
                  req_valid_n = 1'b1;
                  req_state_n = result;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            S_WIN, S_LOSE: if (click_d && back_hit) begin
               req_valid_n = 1'b1;
               req_state_n = S_MENU;
            end
            default: state_n = S_MENU;
         endcase
      end
      // A click seen in the cycle the screen changes belongs to the old screen.
      state_chg = (state_n != state);
      armed_n   = state_chg ? 1'b0 : (armed | ~mouse_left);
      click_n   = mouse_left & ~mouse_left_q & armed & ~state_chg;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_MENU;
         req_state    <= S_MENU;
         result       <= S_LOSE;
         req_valid    <= 1'b0;
         cnt          <= '0;
         armed        <= 1'b0;
         mouse_left_q <= 1'b0;
         click_d      <= 1'b0;
         screen       <= SCR_MENU;
         start_game   <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_n;
         req_state    <= req_state_n;
         result       <= result_n;
         req_valid    <= req_valid_n;
         cnt          <= cnt_n;
         armed        <= armed_n;
         mouse_left_q <= mouse_left;
         click_d      <= click_n;
         screen       <= screen_of(state_n);
         start_game   <= state_chg && (state_n == S_GAME);
         busy         <= req_valid_n || (state_n == S_END_WAIT);
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_screen_ctl.sv
// Directed bench for screen_ctl with a short end delay.
module tb_screen_ctl;
   import snake_pkg::*;

   localparam int END_DELAY = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        frame_tick = 1'b0;
   logic [10:0] mouse_x = '0;
   logic [10:0] mouse_y = '0;
   logic        mouse_left = 1'b0;
   logic        game_over = 1'b0;
   logic        game_won = 1'b0;
   screen_t     screen;
   logic        start_game;
   logic        busy;
   ctl_state_t  dbg_state;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;

   screen_ctl #(.END_DELAY(END_DELAY), .CNT_B(7)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick),
      .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_left(mouse_left),
      .game_over(game_over), .game_won(game_won),
      .screen(screen), .start_game(start_game), .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (start_game) start_cnt <= start_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic click(input logic [10:0] cx, input logic [10:0] cy);
      mouse_x = cx;
      mouse_y = cy;
      step();
      step();
      mouse_left = 1'b1;
      step();
      step();
      mouse_left = 1'b0;
      step();
   endtask

   initial begin
      // Reset with the button already held over the start button.
      mouse_x    = 11'(BUTTONS_X);
      mouse_y    = 11'(BUTTONS_Y);
      mouse_left = 1'b1;
      step();
      chk("rst_screen", screen, SCR_MENU);
      chk("rst_start", start_game, 0);
      chk("rst_busy", busy, 0);
      chk("rst_state", dbg_state, S_MENU);
      rst = 1'b1;
      repeat (4) step();
      chk("held_no_req", busy, 0);
      tick();
      chk("held_menu", screen, SCR_MENU);

      // Release then press: a real click on the start button.
      mouse_left = 1'b0;
      step();
      mouse_left = 1'b1;
      step();
      step();
      chk("start_req", busy, 1);
      chk("start_pending_menu", screen, SCR_MENU);
      mouse_left = 1'b0;
      step();
      chk("no_apply_without_tick", screen, SCR_MENU);
      tick();
      chk("game_screen", screen, SCR_GAME);
      chk("start_pulse", start_game, 1);
      chk("game_busy", busy, 0);
      step();
      chk("start_one_cycle", start_game, 0);
      chk("start_cnt1", start_cnt, 1);

      // Simultaneous over/won: LOSE wins after END_DELAY ticks plus one.
      game_over = 1'b1;
      game_won  = 1'b1;
      step();
      game_over = 1'b0;
      game_won  = 1'b0;
      chk("end_wait_state", dbg_state, S_END_WAIT);
      chk("end_wait_busy", busy, 1);
      chk("end_wait_screen", screen, SCR_GAME);
      tick();
      chk("ew_tick1", screen, SCR_GAME);
      tick();
      chk("ew_tick2", screen, SCR_GAME);
      tick();
      chk("ew_tick3", screen, SCR_GAME);
      chk("ew_tick3_busy", busy, 1);
      tick();
      chk("lose_screen", screen, SCR_LOSE);
      chk("lose_busy", busy, 0);

      // Half-open back button: right edge is outside.
      click(11'(BUTTONS_X + BUTTONS_W), 11'(BUTTONE_Y));
      chk("back_edge_x_miss", busy, 0);
      click(11'(BUTTONS_X), 11'(BUTTONE_Y + BUTTONS_H));
      chk("back_edge_y_miss", busy, 0);

      // Back click coinciding with a frame tick applies on the following tick.
      mouse_x = 11'(BUTTONS_X + 5);
      mouse_y = 11'(BUTTONE_Y + 5);
      step();
      step();
      mouse_left = 1'b1;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk("back_same_tick", screen, SCR_LOSE);
      step();
      mouse_left = 1'b0;
      chk("back_req", busy, 1);
      chk("back_still_lose", screen, SCR_LOSE);
      tick();
      chk("back_menu", screen, SCR_MENU);
      chk("back_no_start", start_game, 0);

      // Half-open start button, then a hit on its last inside pixel.
      click(11'(BUTTONS_X + BUTTONS_W), 11'(BUTTONS_Y));
      chk("start_edge_x_miss", busy, 0);
      click(11'(BUTTONS_X - 1), 11'(BUTTONS_Y));
      chk("start_left_miss", busy, 0);
      click(11'(BUTTONS_X + BUTTONS_W - 1), 11'(BUTTONS_Y + BUTTONS_H - 1));
      chk("start_corner_hit", busy, 1);
      tick();
      chk("game2_screen", screen, SCR_GAME);
      step();
      chk("start_cnt2", start_cnt, 2);

      // Reset during the end delay with cnt = 2.
      game_won = 1'b1;
      step();
      game_won = 1'b0;
      chk("ew2_state", dbg_state, S_END_WAIT);
      tick();
      tick();
      chk("ew2_busy", busy, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_screen", screen, SCR_MENU);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_state", dbg_state, S_MENU);
      step();
      rst = 1'b1;
      repeat (3) step();
      tick();
      tick();
      chk("post_rst_no_start", start_cnt, 2);
      chk("post_rst_menu", screen, SCR_MENU);

      // Full round to the WIN screen.
      click(11'(BUTTONS_X + 10), 11'(BUTTONS_Y + 10));
      tick();
      chk("game3_screen", screen, SCR_GAME);
      game_won = 1'b1;
      step();
      game_won = 1'b0;
      repeat (END_DELAY) tick();
      chk("win_pending", screen, SCR_GAME);
      tick();
      chk("win_screen", screen, SCR_WIN);
      chk("start_cnt3", start_cnt, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
